// File: rtl/mem_stage.sv
// Memory-access stage: retires ALU results, performs word loads/stores on a local
// RAM with fixed latency, and raises branch redirects for taken BEQ and JMP.
module mem_stage #(
   parameter int DEPTH   = 1024,
   parameter int MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [5:0]  ex_op,
   input  logic [31:0] ex_alu_o,
   input  logic [31:0] ex_addr_o,
   input  logic        ex_ife,
   input  logic [4:0]  ex_rd,
   output logic        br_taken,
   output logic [31:0] br_target,
   output logic        wb_valid,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic [31:0] retire_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(MEM_LAT + 1);
   // cnt holds the number of WAIT cycles still to go after the current one
   localparam logic [CW-1:0] CNT_INIT = CW'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   localparam logic [5:0] OP_ALU_MAX = 6'b000101;
   localparam logic [5:0] OP_SW      = 6'b010000;
   localparam logic [5:0] OP_LW      = 6'b010001;
   localparam logic [5:0] OP_BEQ     = 6'b100000;
   localparam logic [5:0] OP_JMP     = 6'b100001;

   logic [0:0]    state;
   logic [CW-1:0] cnt;
   logic          m_lw;
   logic [AW-1:0] m_idx;
   logic [31:0]   m_data;
   logic [4:0]    m_rd;
   logic [31:0]   ram [DEPTH];

   logic          accept;
   logic          is_mem;
   logic          mem_done;
   logic          retire_now;
   logic          c_lw;
   logic [AW-1:0] c_idx;
   logic [31:0]   c_data;
   logic [4:0]    c_rd;
   logic          unused_addr_bits;

   assign ex_ready   = (state == S_IDLE);
   assign accept     = ex_valid & ex_ready;
   assign is_mem     = (ex_op == OP_SW) || (ex_op == OP_LW);
   assign retire_now = mem_done | (accept & ~is_mem);
   assign unused_addr_bits = ^{ex_addr_o[31:AW+2], ex_addr_o[1:0]};

   // Completing access: latched operands in WAIT, live inputs when MEM_LAT is 1
   always_comb begin
      c_lw     = m_lw;
      c_idx    = m_idx;
      c_data   = m_data;
      c_rd     = m_rd;
      mem_done = (state == S_WAIT) && (cnt == '0);
      if (state == S_IDLE) begin
         c_lw     = (ex_op == OP_LW);
         c_idx    = ex_addr_o[AW+1:2];
         c_data   = ex_alu_o;
         c_rd     = ex_rd;
         mem_done = accept && is_mem && (MEM_LAT == 1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && mem_done && !c_lw) begin
         ram[c_idx] <= c_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         m_lw       <= 1'b0;
         m_idx      <= '0;
         m_data     <= '0;
         m_rd       <= '0;
         wb_valid   <= 1'b0;
         wb_we      <= 1'b0;
         wb_rd      <= '0;
         wb_data    <= '0;
         br_taken   <= 1'b0;
         br_target  <= '0;
         retire_cnt <= '0;
      end else begin
         wb_valid  <= retire_now;
         wb_we     <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
         br_taken  <= 1'b0;
         br_target <= '0;
         if (retire_now) begin
            retire_cnt <= retire_cnt + 32'd1;
         end
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (is_mem) begin
                     m_lw   <= (ex_op == OP_LW);
                     m_idx  <= ex_addr_o[AW+1:2];
                     m_data <= ex_alu_o;
                     m_rd   <= ex_rd;
                     if (MEM_LAT > 1) begin
                        state <= S_WAIT;
                        cnt   <= CNT_INIT;
                     end
                  end else begin
                     wb_rd <= ex_rd;
                     if (ex_op <= OP_ALU_MAX) begin
                        wb_we   <= (ex_rd != 5'd0);
                        wb_data <= ex_alu_o;
                     end else if (ex_op == OP_BEQ) begin
                        br_taken  <= ex_ife;
                        br_target <= ex_ife ? ex_addr_o : 32'd0;
                     end else if (ex_op == OP_JMP) begin
                        br_taken  <= 1'b1;
                        br_target <= ex_addr_o;
                     end
                  end
               end
            end
            default: begin
               if (cnt == '0) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
         endcase
         if (mem_done) begin
            wb_rd   <= c_rd;
            wb_we   <= c_lw && (c_rd != 5'd0);
            wb_data <= c_lw ? ram[c_idx] : 32'd0;
         end
      end
   end

endmodule
